// File: rtl/accum_adder_disp_pkg.sv
// Shared types, constants and the hex-to-seven-segment decoder for the
// accumulating adder display block.
package arith_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CNT_P = 2'd1,
        HELD  = 2'd2,
        CNT_R = 2'd3
    } db_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_CLR  = 2'd3
    } acc_op_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low cathode pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/accum_adder_disp_if.sv
// Board-facing bundle: switches and buttons in, accumulator and display out.
interface accum_adder_disp_if #(
    parameter int OP_W       = 4,
    parameter int ACC_W      = 8,
    parameter int NUM_DIGITS = 2
);
    logic [OP_W-1:0]       sw;
    logic                  btn_add;
    logic                  btn_sub;
    logic                  btn_clr;
    logic [ACC_W-1:0]      acc;
    logic                  ovf;
    logic [NUM_DIGITS-1:0] seg_an;
    logic [6:0]            seg_cat;

    modport master (
        output sw, btn_add, btn_sub, btn_clr,
        input  acc, ovf, seg_an, seg_cat
    );

    modport slave (
        input  sw, btn_add, btn_sub, btn_clr,
        output acc, ovf, seg_an, seg_cat
    );
endinterface

// File: rtl/accum_adder_disp_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, press/release debounce FSM,
// and a single registered pulse per accepted press.
module btn_debounce
    import arith_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // State, stability counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next-state logic; the counter restarts on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {CNT_W{1'b0}};
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = CNT_P;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CNT_P: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = CNT_R;
                end else begin
                    w_state_nxt = HELD;
                end
            end
            CNT_R: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Press pulse fires only on the CNT_P -> HELD transition.
    always_comb begin
        if ((r_state == CNT_P) && r_sync2 && (r_cnt == CNT_MAX)) begin
            w_pulse_nxt = 1'b1;
        end else begin
            w_pulse_nxt = 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/accum_adder_disp.sv
// Running accumulator driven by debounced add/sub/clear buttons, with a sticky
// carry/borrow flag and a multiplexed hex seven-segment display.
module accum_adder_disp
    import arith_disp_pkg::*;
#(
    parameter int OP_W         = 4,
    parameter int ACC_W        = 8,
    parameter int NUM_DIGITS   = 2,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REFRESH_DIV  = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    accum_adder_disp_if.slave  bus
);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

    logic [OP_W-1:0]       r_sw_s1;
    logic [OP_W-1:0]       r_sw_s2;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf;
    logic [REF_W-1:0]      r_refresh_cnt;
    logic [IDX_W-1:0]      r_scan_idx;
    logic [NUM_DIGITS-1:0] r_seg_an;
    logic [6:0]            r_seg_cat;

    logic                  w_pulse_add;
    logic                  w_pulse_sub;
    logic                  w_pulse_clr;
    acc_op_e               w_op;
    logic [ACC_W-1:0]      w_sw_ext;
    logic [ACC_W:0]        w_sum;
    logic [ACC_W-1:0]      w_diff;
    logic                  w_borrow;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic                  w_ovf_nxt;
    logic [REF_W-1:0]      w_ref_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DISP_W-1:0]     w_acc_pad;
    logic [3:0]            w_nib;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_add (
        .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_add), .o_pulse(w_pulse_add)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sub (
        .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_sub), .o_pulse(w_pulse_sub)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
        .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_clr), .o_pulse(w_pulse_clr)
    );

    // Two-stage sampling of the operand switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1 <= {OP_W{1'b0}};
            r_sw_s2 <= {OP_W{1'b0}};
        end else begin
            r_sw_s1 <= bus.sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Coincident pulses: clear wins over subtract, subtract over add.
    always_comb begin
        if (w_pulse_clr) begin
            w_op = OP_CLR;
        end else if (w_pulse_sub) begin
            w_op = OP_SUB;
        end else if (w_pulse_add) begin
            w_op = OP_ADD;
        end else begin
            w_op = OP_NONE;
        end
    end

    assign w_sw_ext = ACC_W'(r_sw_s2);
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_sw_ext};
    assign w_diff   = r_acc - w_sw_ext;
    assign w_borrow = (r_acc < w_sw_ext);

    // Accumulator datapath; the flag only ever sets until a clear.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (w_op)
            OP_CLR: begin
                w_acc_nxt = {ACC_W{1'b0}};
                w_ovf_nxt = 1'b0;
            end
            OP_SUB: begin
                w_acc_nxt = w_diff;
                w_ovf_nxt = r_ovf | w_borrow;
            end
            OP_ADD: begin
                w_acc_nxt = w_sum[ACC_W-1:0];
                w_ovf_nxt = r_ovf | w_sum[ACC_W];
            end
            default: begin
                w_acc_nxt = r_acc;
                w_ovf_nxt = r_ovf;
            end
        endcase
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Refresh divider and digit index advance.
    always_comb begin
        if (r_refresh_cnt == REF_MAX) begin
            w_ref_nxt = {REF_W{1'b0}};
            if (r_scan_idx == IDX_MAX) begin
                w_idx_nxt = {IDX_W{1'b0}};
            end else begin
                w_idx_nxt = r_scan_idx + IDX_W'(1);
            end
        end else begin
            w_ref_nxt = r_refresh_cnt + REF_W'(1);
            w_idx_nxt = r_scan_idx;
        end
    end

    // Zero padding makes digits beyond the accumulator width read as 0.
    assign w_acc_pad = DISP_W'(r_acc);
    assign w_nib     = 4'(w_acc_pad >> {w_idx_nxt, 2'b00});

    // Anode and cathode both come from the next index so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= {REF_W{1'b0}};
            r_scan_idx    <= {IDX_W{1'b0}};
            r_seg_an      <= ~(NUM_DIGITS'(1));
            r_seg_cat     <= hex7seg(4'h0);
        end else begin
            r_refresh_cnt <= w_ref_nxt;
            r_scan_idx    <= w_idx_nxt;
            r_seg_an      <= ~(NUM_DIGITS'(1) << w_idx_nxt);
            r_seg_cat     <= hex7seg(w_nib);
        end
    end

    assign bus.acc     = r_acc;
    assign bus.ovf     = r_ovf;
    assign bus.seg_an  = r_seg_an;
    assign bus.seg_cat = r_seg_cat;

endmodule
